axi_dma_s2mm_controller: RTL and testbench

AXI-Lite master that sequences one AXI DMA S2MM (stream-to-memory) receive transfer per request. On a start pulse it programs the DMA control, destination-address and length registers in order. It then polls the status register until completion or error, clears the IOC flag and reports done or error. It sits between the processor-side request logic and the DMA's AXI-Lite slave port. Its length write at offset 0x58 is the event that the existing receive-transfer tap detects.

---
 rtl/axi_dma_pkg.sv | 52 +++++
 rtl/axi_lite_single_master.sv | 139 +++++++++++++
 rtl/axi_dma_s2mm_controller.sv | 238 +++++++++++++++++++++++
 tb/tb_axi_dma_s2mm_controller.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_dma_pkg.sv
// Shared definitions for the S2MM DMA sequencer: register map, DMASR bit
// positions, failure codes and the sequencer state encoding.
package axi_dma_pkg;

    // DMA AXI-Lite register offsets (S2MM channel)
    localparam logic [9:0] S2MM_DMACR  = 10'h030;
    localparam logic [9:0] S2MM_DMASR  = 10'h034;
    localparam logic [9:0] S2MM_DA     = 10'h048;
    localparam logic [9:0] S2MM_LENGTH = 10'h058;

    // DMASR bit indices
    localparam int DMASR_IDLE   = 1;
    localparam int DMASR_INTERR = 4;
    localparam int DMASR_SLVERR = 5;
    localparam int DMASR_DECERR = 6;
    localparam int DMASR_IOC    = 12;

    // Values written to the DMA
    localparam logic [31:0] DMACR_RUN     = 32'h0000_0001;
    localparam logic [31:0] DMASR_IOC_W1C = 32'h0000_1000;

    // Failure causes reported on err_code
    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_BRESP    = 3'd1;
    localparam logic [2:0] ERR_RRESP    = 3'd2;
    localparam logic [2:0] ERR_DMA      = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT  = 3'd4;
    localparam logic [2:0] ERR_ZERO_LEN = 3'd5;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_WR_CR     = 4'd1,
        ST_WR_DA     = 4'd2,
        ST_WR_LEN    = 4'd3,
        ST_POLL_WAIT = 4'd4,
        ST_POLL_RD   = 4'd5,
        ST_WR_CLR    = 4'd6,
        ST_FIN_OK    = 4'd7,
        ST_FIN_ERR   = 4'd8
    } state_e;

    // Any of the three DMA error flags set
    function automatic logic dmasr_has_error(input logic [31:0] sr);
        return sr[DMASR_INTERR] | sr[DMASR_SLVERR] | sr[DMASR_DECERR];
    endfunction

    // Transfer finished: completion interrupt or channel idle
    function automatic logic dmasr_is_complete(input logic [31:0] sr);
        return sr[DMASR_IOC] | sr[DMASR_IDLE];
    endfunction

endpackage

// File: rtl/axi_lite_single_master.sv
// Single-transaction AXI-Lite master: one write or one read per command,
// result returned with a one-cycle rsp_done strobe. Commands presented while
// a transaction is in flight are ignored.
module axi_lite_single_master #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [31:0]       cmd_wdata,
    output logic              rsp_done,
    output logic [1:0]        rsp_resp,
    output logic [31:0]       rsp_rdata,
    output logic [ADDR_W-1:0] m_axi_lite_awaddr,
    output logic              m_axi_lite_awvalid,
    input  logic              m_axi_lite_awready,
    output logic [31:0]       m_axi_lite_wdata,
    output logic              m_axi_lite_wvalid,
    input  logic              m_axi_lite_wready,
    input  logic [1:0]        m_axi_lite_bresp,
    input  logic              m_axi_lite_bvalid,
    output logic              m_axi_lite_bready,
    output logic [ADDR_W-1:0] m_axi_lite_araddr,
    output logic              m_axi_lite_arvalid,
    input  logic              m_axi_lite_arready,
    input  logic [31:0]       m_axi_lite_rdata,
    input  logic [1:0]        m_axi_lite_rresp,
    input  logic              m_axi_lite_rvalid,
    output logic              m_axi_lite_rready
);

    logic              aw_pend_q, aw_pend_d;
    logic              w_pend_q,  w_pend_d;
    logic              bready_q,  bready_d;
    logic              wr_act_q,  wr_act_d;
    logic              ar_pend_q, ar_pend_d;
    logic              rready_q,  rready_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic [31:0]       wdata_q,   wdata_d;
    logic              done_q,    done_d;
    logic [1:0]        resp_q,    resp_d;
    logic [31:0]       rdata_q,   rdata_d;
    logic              idle_s;

    assign idle_s = ~wr_act_q & ~ar_pend_q & ~rready_q;

    // Channel handshake sequencing for the single outstanding transaction
    always_comb begin
        aw_pend_d = aw_pend_q & ~m_axi_lite_awready;
        w_pend_d  = w_pend_q  & ~m_axi_lite_wready;
        bready_d  = bready_q;
        wr_act_d  = wr_act_q;
        ar_pend_d = ar_pend_q;
        rready_d  = rready_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        done_d    = 1'b0;
        resp_d    = resp_q;
        rdata_d   = rdata_q;
        if (cmd_valid && idle_s) begin
            addr_d  = cmd_addr;
            wdata_d = cmd_wdata;
            if (cmd_write) begin
                aw_pend_d = 1'b1;
                w_pend_d  = 1'b1;
                wr_act_d  = 1'b1;
            end else begin
                ar_pend_d = 1'b1;
            end
        end else begin
            // Response phase opens only once both address and data are accepted
            if (wr_act_q && !bready_q && !aw_pend_d && !w_pend_d) begin
                bready_d = 1'b1;
            end else if (bready_q && m_axi_lite_bvalid) begin
                bready_d = 1'b0;
                wr_act_d = 1'b0;
                done_d   = 1'b1;
                resp_d   = m_axi_lite_bresp;
            end else begin
                bready_d = bready_q;
            end
            if (ar_pend_q && m_axi_lite_arready) begin
                ar_pend_d = 1'b0;
                rready_d  = 1'b1;
            end else if (rready_q && m_axi_lite_rvalid) begin
                rready_d = 1'b0;
                done_d   = 1'b1;
                resp_d   = m_axi_lite_rresp;
                rdata_d  = m_axi_lite_rdata;
            end else begin
                rready_d = rready_q;
            end
        end
    end

    // Transaction state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
            bready_q  <= 1'b0;
            wr_act_q  <= 1'b0;
            ar_pend_q <= 1'b0;
            rready_q  <= 1'b0;
            addr_q    <= {ADDR_W{1'b0}};
            wdata_q   <= 32'h0;
            done_q    <= 1'b0;
            resp_q    <= 2'b00;
            rdata_q   <= 32'h0;
        end else begin
            aw_pend_q <= aw_pend_d;
            w_pend_q  <= w_pend_d;
            bready_q  <= bready_d;
            wr_act_q  <= wr_act_d;
            ar_pend_q <= ar_pend_d;
            rready_q  <= rready_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            done_q    <= done_d;
            resp_q    <= resp_d;
            rdata_q   <= rdata_d;
        end
    end

    assign m_axi_lite_awaddr  = addr_q;
    assign m_axi_lite_awvalid = aw_pend_q;
    assign m_axi_lite_wdata   = wdata_q;
    assign m_axi_lite_wvalid  = w_pend_q;
    assign m_axi_lite_bready  = bready_q;
    assign m_axi_lite_araddr  = addr_q;
    assign m_axi_lite_arvalid = ar_pend_q;
    assign m_axi_lite_rready  = rready_q;
    assign rsp_done           = done_q;
    assign rsp_resp           = resp_q;
    assign rsp_rdata          = rdata_q;

endmodule

// File: rtl/axi_dma_s2mm_controller.sv
// Sequences one AXI DMA S2MM receive transfer per start request: program
// DMACR, DA and LENGTH (length last, it kicks the DMA), poll DMASR, clear IOC.
module axi_dma_s2mm_controller
    import axi_dma_pkg::*;
#(
    parameter int ADDR_W       = 10,
    parameter int LEN_W        = 26,
    parameter int POLL_GAP     = 16,
    parameter int POLL_TIMEOUT = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [31:0]       dest_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [2:0]        err_code,
    output logic [31:0]       last_status,
    output logic [ADDR_W-1:0] m_axi_lite_awaddr,
    output logic              m_axi_lite_awvalid,
    input  logic              m_axi_lite_awready,
    output logic [31:0]       m_axi_lite_wdata,
    output logic              m_axi_lite_wvalid,
    input  logic              m_axi_lite_wready,
    input  logic [1:0]        m_axi_lite_bresp,
    input  logic              m_axi_lite_bvalid,
    output logic              m_axi_lite_bready,
    output logic [ADDR_W-1:0] m_axi_lite_araddr,
    output logic              m_axi_lite_arvalid,
    input  logic              m_axi_lite_arready,
    input  logic [31:0]       m_axi_lite_rdata,
    input  logic [1:0]        m_axi_lite_rresp,
    input  logic              m_axi_lite_rvalid,
    output logic              m_axi_lite_rready
);

    state_e            state_q, state_d;
    logic [31:0]       dest_q, dest_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [2:0]        err_code_q, err_code_d;
    logic [31:0]       last_status_q, last_status_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              issued_q, issued_d;
    logic [31:0]       gap_cnt_q, gap_cnt_d;
    logic [31:0]       poll_cnt_q, poll_cnt_d;

    logic              cmd_valid_s;
    logic              cmd_write_s;
    logic [ADDR_W-1:0] cmd_addr_s;
    logic [31:0]       cmd_wdata_s;
    logic              rsp_done_s;
    logic [1:0]        rsp_resp_s;
    logic [31:0]       rsp_rdata_s;

    axi_lite_single_master #(.ADDR_W(ADDR_W)) u_master (
        .clk                (clk),
        .rst                (rst),
        .cmd_valid          (cmd_valid_s),
        .cmd_write          (cmd_write_s),
        .cmd_addr           (cmd_addr_s),
        .cmd_wdata          (cmd_wdata_s),
        .rsp_done           (rsp_done_s),
        .rsp_resp           (rsp_resp_s),
        .rsp_rdata          (rsp_rdata_s),
        .m_axi_lite_awaddr  (m_axi_lite_awaddr),
        .m_axi_lite_awvalid (m_axi_lite_awvalid),
        .m_axi_lite_awready (m_axi_lite_awready),
        .m_axi_lite_wdata   (m_axi_lite_wdata),
        .m_axi_lite_wvalid  (m_axi_lite_wvalid),
        .m_axi_lite_wready  (m_axi_lite_wready),
        .m_axi_lite_bresp   (m_axi_lite_bresp),
        .m_axi_lite_bvalid  (m_axi_lite_bvalid),
        .m_axi_lite_bready  (m_axi_lite_bready),
        .m_axi_lite_araddr  (m_axi_lite_araddr),
        .m_axi_lite_arvalid (m_axi_lite_arvalid),
        .m_axi_lite_arready (m_axi_lite_arready),
        .m_axi_lite_rdata   (m_axi_lite_rdata),
        .m_axi_lite_rresp   (m_axi_lite_rresp),
        .m_axi_lite_rvalid  (m_axi_lite_rvalid),
        .m_axi_lite_rready  (m_axi_lite_rready)
    );

    // Next-state, register-operation issue and status decode
    always_comb begin
        state_d       = state_q;
        dest_d        = dest_q;
        len_d         = len_q;
        err_code_d    = err_code_q;
        last_status_d = last_status_q;
        gap_cnt_d     = gap_cnt_q;
        poll_cnt_d    = poll_cnt_q;
        cmd_valid_s   = 1'b0;
        cmd_write_s   = 1'b1;
        cmd_addr_s    = {ADDR_W{1'b0}};
        cmd_wdata_s   = 32'h0;
        case (state_q)
            ST_IDLE: begin
                if (!start) begin
                    state_d = ST_IDLE;
                end else if (length == {LEN_W{1'b0}}) begin
                    err_code_d = ERR_ZERO_LEN;
                    state_d    = ST_FIN_ERR;
                end else begin
                    dest_d     = dest_addr;
                    len_d      = length;
                    err_code_d = ERR_NONE;
                    gap_cnt_d  = 32'd0;
                    poll_cnt_d = 32'd0;
                    state_d    = ST_WR_CR;
                end
            end
            ST_WR_CR, ST_WR_DA, ST_WR_LEN, ST_WR_CLR: begin
                cmd_valid_s = ~issued_q;
                case (state_q)
                    ST_WR_CR: begin
                        cmd_addr_s  = ADDR_W'(S2MM_DMACR);
                        cmd_wdata_s = DMACR_RUN;
                    end
                    ST_WR_DA: begin
                        cmd_addr_s  = ADDR_W'(S2MM_DA);
                        cmd_wdata_s = dest_q;
                    end
                    ST_WR_LEN: begin
                        cmd_addr_s  = ADDR_W'(S2MM_LENGTH);
                        cmd_wdata_s = 32'(len_q);
                    end
                    default: begin
                        cmd_addr_s  = ADDR_W'(S2MM_DMASR);
                        cmd_wdata_s = DMASR_IOC_W1C;
                    end
                endcase
                if (!rsp_done_s) begin
                    state_d = state_q;
                end else if (rsp_resp_s != 2'b00) begin
                    err_code_d = ERR_BRESP;
                    state_d    = ST_FIN_ERR;
                end else begin
                    case (state_q)
                        ST_WR_CR:  state_d = ST_WR_DA;
                        ST_WR_DA:  state_d = ST_WR_LEN;
                        ST_WR_LEN: state_d = ST_POLL_WAIT;
                        default:   state_d = ST_FIN_OK;
                    endcase
                end
            end
            ST_POLL_WAIT: begin
                if (gap_cnt_q >= 32'(POLL_GAP - 1)) begin
                    gap_cnt_d = 32'd0;
                    state_d   = ST_POLL_RD;
                end else begin
                    gap_cnt_d = gap_cnt_q + 32'd1;
                end
            end
            ST_POLL_RD: begin
                cmd_valid_s = ~issued_q;
                cmd_write_s = 1'b0;
                cmd_addr_s  = ADDR_W'(S2MM_DMASR);
                if (!rsp_done_s) begin
                    state_d = ST_POLL_RD;
                end else begin
                    last_status_d = rsp_rdata_s;
                    if (rsp_resp_s != 2'b00) begin
                        err_code_d = ERR_RRESP;
                        state_d    = ST_FIN_ERR;
                    end else if (dmasr_has_error(rsp_rdata_s)) begin
                        err_code_d = ERR_DMA;
                        state_d    = ST_FIN_ERR;
                    end else if (dmasr_is_complete(rsp_rdata_s)) begin
                        state_d = ST_WR_CLR;
                    end else if (poll_cnt_q + 32'd1 >= 32'(POLL_TIMEOUT)) begin
                        poll_cnt_d = poll_cnt_q + 32'd1;
                        err_code_d = ERR_TIMEOUT;
                        state_d    = ST_FIN_ERR;
                    end else begin
                        poll_cnt_d = poll_cnt_q + 32'd1;
                        state_d    = ST_POLL_WAIT;
                    end
                end
            end
            ST_FIN_OK:  state_d = ST_IDLE;
            ST_FIN_ERR: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase

        // One command per register operation; re-armed when its response returns
        if (rsp_done_s) begin
            issued_d = 1'b0;
        end else if (cmd_valid_s) begin
            issued_d = 1'b1;
        end else begin
            issued_d = issued_q;
        end

        busy_d  = (state_d != ST_IDLE) && (state_d != ST_FIN_OK) && (state_d != ST_FIN_ERR);
        done_d  = (state_d == ST_FIN_OK);
        error_d = (state_d == ST_FIN_ERR);
    end

    // Sequencer state and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            dest_q        <= 32'h0;
            len_q         <= {LEN_W{1'b0}};
            err_code_q    <= ERR_NONE;
            last_status_q <= 32'h0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            issued_q      <= 1'b0;
            gap_cnt_q     <= 32'd0;
            poll_cnt_q    <= 32'd0;
        end else begin
            state_q       <= state_d;
            dest_q        <= dest_d;
            len_q         <= len_d;
            err_code_q    <= err_code_d;
            last_status_q <= last_status_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            error_q       <= error_d;
            issued_q      <= issued_d;
            gap_cnt_q     <= gap_cnt_d;
            poll_cnt_q    <= poll_cnt_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;
    assign err_code    = err_code_q;
    assign last_status = last_status_q;

endmodule

// File: tb/tb_axi_dma_s2mm_controller.sv
// Bench for axi_dma_s2mm_controller: reactive AXI-Lite slave model with
// scripted DMASR values, scoreboards for register writes and outcomes.
module tb_axi_dma_s2mm_controller;

    localparam int ADDR_W       = 10;
    localparam int LEN_W        = 26;
    localparam int POLL_GAP     = 2;
    localparam int POLL_TIMEOUT = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [31:0]       dest_addr = 32'h0;
    logic [LEN_W-1:0]  length = '0;
    logic              busy, done, error;
    logic [2:0]        err_code;
    logic [31:0]       last_status;
    logic [ADDR_W-1:0] m_axi_lite_awaddr, m_axi_lite_araddr;
    logic              m_axi_lite_awvalid, m_axi_lite_wvalid, m_axi_lite_bready;
    logic              m_axi_lite_arvalid, m_axi_lite_rready;
    logic [31:0]       m_axi_lite_wdata;
    logic              m_axi_lite_awready = 1'b0, m_axi_lite_wready = 1'b0;
    logic [1:0]        m_axi_lite_bresp = 2'b00, m_axi_lite_rresp = 2'b00;
    logic              m_axi_lite_bvalid = 1'b0, m_axi_lite_arready = 1'b0, m_axi_lite_rvalid = 1'b0;
    logic [31:0]       m_axi_lite_rdata = 32'h0;

    axi_dma_s2mm_controller #(
        .ADDR_W(ADDR_W), .LEN_W(LEN_W), .POLL_GAP(POLL_GAP), .POLL_TIMEOUT(POLL_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .dest_addr(dest_addr), .length(length),
        .busy(busy), .done(done), .error(error), .err_code(err_code), .last_status(last_status),
        .m_axi_lite_awaddr(m_axi_lite_awaddr), .m_axi_lite_awvalid(m_axi_lite_awvalid),
        .m_axi_lite_awready(m_axi_lite_awready), .m_axi_lite_wdata(m_axi_lite_wdata),
        .m_axi_lite_wvalid(m_axi_lite_wvalid), .m_axi_lite_wready(m_axi_lite_wready),
        .m_axi_lite_bresp(m_axi_lite_bresp), .m_axi_lite_bvalid(m_axi_lite_bvalid),
        .m_axi_lite_bready(m_axi_lite_bready), .m_axi_lite_araddr(m_axi_lite_araddr),
        .m_axi_lite_arvalid(m_axi_lite_arvalid), .m_axi_lite_arready(m_axi_lite_arready),
        .m_axi_lite_rdata(m_axi_lite_rdata), .m_axi_lite_rresp(m_axi_lite_rresp),
        .m_axi_lite_rvalid(m_axi_lite_rvalid), .m_axi_lite_rready(m_axi_lite_rready)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Scoreboards: {addr[9:0], data[31:0]} and {is_err, code[2:0], status[31:0]}
    logic [41:0] exp_wr[$];
    logic [35:0] exp_out[$];
    logic [31:0] status_script[$];
    logic [31:0] status_default = 32'h0;

    int skew_mode = 0;
    logic [ADDR_W-1:0] bresp_err_addr = 10'h3FF;
    int wr_idx = 0, rd_cnt = 0, len_wr_cnt = 0, valid_seen = 0;

    // Slave-model state
    logic aw_fire_pend = 1'b0, aw_got = 1'b0, aw_track = 1'b0;
    logic w_fire_pend = 1'b0, w_got = 1'b0, w_track = 1'b0;
    logic b_fire_pend = 1'b0, ar_fire_pend = 1'b0, r_fire_pend = 1'b0, busy_chk = 1'b0;
    int aw_wait = 0, w_wait = 0;
    logic [ADDR_W-1:0] aw_hold, aw_addr_got;
    logic [31:0] w_hold, w_data_got;
    logic [35:0] eo;
    logic [41:0] ew;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int aw_dly();
        if (skew_mode == 1 && wr_idx == 0) return 3;
        else if (skew_mode == 2) return 5;
        else return 0;
    endfunction

    function automatic int w_dly();
        if (skew_mode == 1 && wr_idx == 1) return 3;
        else return 0;
    endfunction

    // Reactive AXI-Lite slave plus output monitor, acting on the falling edge
    always @(negedge clk) begin
        if (rst) begin
            m_axi_lite_awready = 1'b0; m_axi_lite_wready = 1'b0; m_axi_lite_bvalid = 1'b0;
            m_axi_lite_arready = 1'b0; m_axi_lite_rvalid = 1'b0;
            aw_fire_pend = 1'b0; aw_got = 1'b0; aw_track = 1'b0;
            w_fire_pend = 1'b0; w_got = 1'b0; w_track = 1'b0;
            b_fire_pend = 1'b0; ar_fire_pend = 1'b0; r_fire_pend = 1'b0; busy_chk = 1'b0;
        end else begin
            if ((m_axi_lite_awvalid || m_axi_lite_wvalid) && m_axi_lite_arvalid)
                check_val("ch_excl", 32'd1, 32'd0);
            if (m_axi_lite_awvalid || m_axi_lite_wvalid || m_axi_lite_arvalid) valid_seen++;
            // write address channel
            if (aw_fire_pend) begin
                m_axi_lite_awready = 1'b0; aw_fire_pend = 1'b0; aw_got = 1'b1; aw_track = 1'b0;
                check_val("aw_drop", 32'(m_axi_lite_awvalid), 32'd0);
            end else if (m_axi_lite_awvalid && !aw_got) begin
                if (!aw_track) begin aw_track = 1'b1; aw_hold = m_axi_lite_awaddr; aw_wait = 0; end
                else check_val("aw_stable", 32'(m_axi_lite_awaddr), 32'(aw_hold));
                if (aw_wait >= aw_dly()) begin
                    m_axi_lite_awready = 1'b1; aw_fire_pend = 1'b1; aw_addr_got = m_axi_lite_awaddr;
                end else aw_wait++;
            end
            // write data channel
            if (w_fire_pend) begin
                m_axi_lite_wready = 1'b0; w_fire_pend = 1'b0; w_got = 1'b1; w_track = 1'b0;
                check_val("w_drop", 32'(m_axi_lite_wvalid), 32'd0);
            end else if (m_axi_lite_wvalid && !w_got) begin
                if (!w_track) begin w_track = 1'b1; w_hold = m_axi_lite_wdata; w_wait = 0; end
                else check_val("w_stable", m_axi_lite_wdata, w_hold);
                if (w_wait >= w_dly()) begin
                    m_axi_lite_wready = 1'b1; w_fire_pend = 1'b1; w_data_got = m_axi_lite_wdata;
                end else w_wait++;
            end
            // write response channel; the completed write is scored here
            if (b_fire_pend) begin
                m_axi_lite_bvalid = 1'b0; b_fire_pend = 1'b0;
            end else if (!m_axi_lite_bvalid && aw_got && w_got) begin
                aw_got = 1'b0; w_got = 1'b0;
                if (aw_addr_got == 10'h058) len_wr_cnt++;
                if (exp_wr.size() == 0) check_val("wr_extra", 32'(aw_addr_got), 32'hFFFF_FFFF);
                else begin
                    ew = exp_wr.pop_front();
                    check_val("wr_addr", 32'(aw_addr_got), 32'(ew[41:32]));
                    check_val("wr_data", w_data_got, ew[31:0]);
                end
                m_axi_lite_bresp = (aw_addr_got == bresp_err_addr) ? 2'b10 : 2'b00;
                m_axi_lite_bvalid = 1'b1;
                wr_idx++;
            end
            if (m_axi_lite_bvalid && m_axi_lite_bready) b_fire_pend = 1'b1;
            // read channels
            if (r_fire_pend) begin m_axi_lite_rvalid = 1'b0; r_fire_pend = 1'b0; end
            if (ar_fire_pend) begin
                m_axi_lite_arready = 1'b0; ar_fire_pend = 1'b0;
                m_axi_lite_rvalid = 1'b1; m_axi_lite_rresp = 2'b00;
                m_axi_lite_rdata = (status_script.size() > 0) ? status_script.pop_front() : status_default;
                rd_cnt++;
            end else if (m_axi_lite_arvalid && !m_axi_lite_arready) begin
                check_val("ar_addr", 32'(m_axi_lite_araddr), 32'h034);
                m_axi_lite_arready = 1'b1; ar_fire_pend = 1'b1;
            end
            if (m_axi_lite_rvalid && m_axi_lite_rready) r_fire_pend = 1'b1;
            // outcome scoreboard
            if (busy_chk) begin check_val("busy_after", 32'(busy), 32'd0); busy_chk = 1'b0; end
            if (done || error) begin
                if (exp_out.size() == 0) check_val("out_extra", 32'd1, 32'd0);
                else begin
                    eo = exp_out.pop_front();
                    check_val("out_error", 32'(error), 32'(eo[35]));
                    check_val("out_done", 32'(done), 32'(!eo[35]));
                    check_val("err_code", 32'(err_code), 32'(eo[34:32]));
                    check_val("last_status", last_status, eo[31:0]);
                    check_val("busy_fin", 32'(busy), 32'd0);
                    busy_chk = 1'b1;
                end
            end
        end
    end

    task automatic pulse_start(input logic [31:0] d, input logic [LEN_W-1:0] l);
        @(negedge clk);
        dest_addr = d; length = l; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_outcome();
        for (int i = 0; i < 3000 && exp_out.size() != 0; i++) @(negedge clk);
        if (exp_out.size() != 0) begin
            check_val("wait_timeout", 32'd1, 32'd0);
            exp_out.delete();
        end
        repeat (3) @(negedge clk);
        check_val("wr_left", 32'(exp_wr.size()), 32'd0);
        exp_wr.delete();
    endtask

    task automatic push_setup(input logic [31:0] d, input logic [LEN_W-1:0] l);
        exp_wr.push_back({10'h030, 32'h0000_0001});
        exp_wr.push_back({10'h048, d});
        exp_wr.push_back({10'h058, 32'(l)});
    endtask

    task automatic begin_test();
        wr_idx = 0; rd_cnt = 0; len_wr_cnt = 0; valid_seen = 0;
        status_script.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done_err", 32'({done, error}), 32'd0);
        check_val("rst_valids", 32'({m_axi_lite_awvalid, m_axi_lite_wvalid, m_axi_lite_arvalid,
                                     m_axi_lite_bready, m_axi_lite_rready}), 32'd0);
        check_val("rst_err_code", 32'(err_code), 32'd0);
        check_val("rst_status", last_status, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Normal transfer
        begin_test();
        status_script.push_back(32'h0); status_script.push_back(32'h0); status_script.push_back(32'h1002);
        push_setup(32'h1000_0000, 26'd256);
        exp_wr.push_back({10'h034, 32'h0000_1000});
        exp_out.push_back({1'b0, 3'd0, 32'h1002});
        pulse_start(32'h1000_0000, 26'd256);
        wait_outcome();
        check_val("normal_reads", 32'(rd_cnt), 32'd3);

        // Handshake skew
        begin_test();
        skew_mode = 1;
        status_script.push_back(32'h2);
        push_setup(32'h0ABC_0040, 26'd1000);
        exp_wr.push_back({10'h034, 32'h0000_1000});
        exp_out.push_back({1'b0, 3'd0, 32'h2});
        pulse_start(32'h0ABC_0040, 26'd1000);
        wait_outcome();
        skew_mode = 0;

        // Write response error on the DA write
        begin_test();
        bresp_err_addr = 10'h048;
        exp_wr.push_back({10'h030, 32'h0000_0001});
        exp_wr.push_back({10'h048, 32'h2000_0000});
        exp_out.push_back({1'b1, 3'd1, 32'h2});
        pulse_start(32'h2000_0000, 26'd64);
        wait_outcome();
        check_val("bresp_no_len", 32'(len_wr_cnt), 32'd0);
        bresp_err_addr = 10'h3FF;

        // DMA status error
        begin_test();
        status_script.push_back(32'h0000_0020);
        push_setup(32'h3000_0000, 26'd16);
        exp_out.push_back({1'b1, 3'd3, 32'h20});
        pulse_start(32'h3000_0000, 26'd16);
        wait_outcome();
        check_val("dmaerr_reads", 32'(rd_cnt), 32'd1);

        // Poll timeout
        begin_test();
        status_default = 32'h0;
        push_setup(32'h3100_0000, 26'h3FF_FFFF);
        exp_out.push_back({1'b1, 3'd4, 32'h0});
        pulse_start(32'h3100_0000, 26'h3FF_FFFF);
        wait_outcome();
        check_val("timeout_reads", 32'(rd_cnt), 32'd4);

        // Zero length
        begin_test();
        exp_out.push_back({1'b1, 3'd5, 32'h0});
        pulse_start(32'h3200_0000, 26'd0);
        wait_outcome();
        check_val("zero_len_valids", 32'(valid_seen), 32'd0);

        // Start while busy is ignored
        begin_test();
        status_script.push_back(32'h0); status_script.push_back(32'h1002);
        push_setup(32'h4000_0000, 26'd64);
        exp_wr.push_back({10'h034, 32'h0000_1000});
        exp_out.push_back({1'b0, 3'd0, 32'h1002});
        pulse_start(32'h4000_0000, 26'd64);
        repeat (2) @(negedge clk);
        check_val("busy_hi", 32'(busy), 32'd1);
        pulse_start(32'h5000_0000, 26'd128);
        wait_outcome();
        check_val("one_len_write", 32'(len_wr_cnt), 32'd1);

        // Reset during the LENGTH write
        begin_test();
        skew_mode = 2;
        exp_wr.push_back({10'h030, 32'h0000_0001});
        exp_wr.push_back({10'h048, 32'h6000_0000});
        pulse_start(32'h6000_0000, 26'd32);
        for (int i = 0; i < 200 && !(m_axi_lite_awvalid && m_axi_lite_awaddr == 10'h058); i++)
            @(negedge clk);
        check_val("len_aw_seen", 32'(m_axi_lite_awvalid), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_val("midrst_valids", 32'({m_axi_lite_awvalid, m_axi_lite_wvalid, m_axi_lite_arvalid}), 32'd0);
        check_val("midrst_busy", 32'(busy), 32'd0);
        check_val("midrst_err_code", 32'(err_code), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        skew_mode = 0;
        exp_wr.delete(); exp_out.delete();
        repeat (2) @(negedge clk);

        begin_test();
        status_script.push_back(32'h1000);
        push_setup(32'h7000_0000, 26'd512);
        exp_wr.push_back({10'h034, 32'h0000_1000});
        exp_out.push_back({1'b0, 3'd0, 32'h1000});
        pulse_start(32'h7000_0000, 26'd512);
        wait_outcome();
        check_val("post_rst_reads", 32'(rd_cnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
